// File: rtl/otter_immed_pkg.sv
// Shared opcode constants and immediate-format tags for the OTTER immediate pipe.
package otter_immed_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_REG32  = 7'b0111011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    IMM_R  = 3'd0,
    IMM_I  = 3'd1,
    IMM_S  = 3'd2,
    IMM_B  = 3'd3,
    IMM_U  = 3'd4,
    IMM_J  = 3'd5,
    IMM_SH = 3'd6
  } imm_type_t;

endpackage

// File: rtl/otter_immed_decode.sv
// Combinational decode of one instruction word into its immediate, format tag,
// PC-relative target and illegal flag.
module otter_immed_decode
  import otter_immed_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     ir_i,
  input  logic [XLEN-1:0] pc_i,
  output logic [XLEN-1:0] imm_o,
  output imm_type_t       type_o,
  output logic [XLEN-1:0] target_o,
  output logic            illegal_o
);

  logic [XLEN-1:0] u_imm, j_imm, i_imm, s_imm, b_imm, sh_imm, sh32_imm;
  logic            is_shift;
  logic            pc_rel;

  // Signed size casts do the sign extension to XLEN.
  assign u_imm    = XLEN'($signed({ir_i[31:12], 12'b0}));
  assign j_imm    = XLEN'($signed({ir_i[31], ir_i[19:12], ir_i[20], ir_i[30:21], 1'b0}));
  assign i_imm    = XLEN'($signed(ir_i[31:20]));
  assign s_imm    = XLEN'($signed({ir_i[31:25], ir_i[11:7]}));
  assign b_imm    = XLEN'($signed({ir_i[31], ir_i[7], ir_i[30:25], ir_i[11:8], 1'b0}));
  assign sh_imm   = (XLEN == 64) ? XLEN'(ir_i[25:20]) : XLEN'(ir_i[24:20]);
  assign sh32_imm = XLEN'(ir_i[24:20]);
  assign is_shift = (ir_i[14:12] == 3'b001) || (ir_i[14:12] == 3'b101);

  always_comb begin
    imm_o     = '0;
    type_o    = IMM_R;
    illegal_o = 1'b0;
    pc_rel    = 1'b0;
    if (ir_i[1:0] != 2'b11) begin
      illegal_o = 1'b1;
    end else begin
      case (ir_i[6:0])
        OP_LUI:   begin type_o = IMM_U; imm_o = u_imm; end
        OP_AUIPC: begin type_o = IMM_U; imm_o = u_imm; pc_rel = 1'b1; end
        OP_JAL:   begin type_o = IMM_J; imm_o = j_imm; pc_rel = 1'b1; end
        OP_JALR, OP_LOAD, OP_SYSTEM: begin type_o = IMM_I; imm_o = i_imm; end
        OP_IMM: begin
          if (is_shift) begin type_o = IMM_SH; imm_o = sh_imm; end
          else          begin type_o = IMM_I;  imm_o = i_imm;  end
        end
        OP_IMM32: begin
          if (XLEN != 64)    illegal_o = 1'b1;
          else if (is_shift) begin type_o = IMM_SH; imm_o = sh32_imm; end
          else               begin type_o = IMM_I;  imm_o = i_imm;    end
        end
        OP_STORE:  begin type_o = IMM_S; imm_o = s_imm; end
        OP_BRANCH: begin type_o = IMM_B; imm_o = b_imm; pc_rel = 1'b1; end
        OP_REG:    type_o = IMM_R;
        OP_REG32:  illegal_o = (XLEN != 64);
        default:   illegal_o = 1'b1;
      endcase
    end
  end

  assign target_o = pc_rel ? (pc_i + imm_o) : '0;

endmodule

// File: rtl/otter_immed_gen_pipe.sv
// Registered immediate generator stage between fetch and decode, with an
// optional two-entry skid buffer on the valid/ready handshake.
module otter_immed_gen_pipe
  import otter_immed_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter bit          SKID = 1'b1
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            FLUSH,
  input  logic            IN_VALID,
  output logic            IN_READY,
  input  logic [31:0]     IN_IR,
  input  logic [XLEN-1:0] IN_PC,
  output logic            OUT_VALID,
  input  logic            OUT_READY,
  output logic [XLEN-1:0] OUT_IMM,
  output imm_type_t       OUT_TYPE,
  output logic [XLEN-1:0] OUT_TARGET,
  output logic [31:0]     OUT_IR,
  output logic [XLEN-1:0] OUT_PC,
  output logic            OUT_ILLEGAL
);

  typedef struct packed {
    logic [XLEN-1:0] imm;
    imm_type_t       typ;
    logic [XLEN-1:0] tgt;
    logic [31:0]     ir;
    logic [XLEN-1:0] pc;
    logic            ill;
  } entry_t;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]      state_q, state_d;
  logic            rdy_q;
  entry_t          out_q, skid_q, dec;
  logic            in_fire, out_fire;
  logic            ld_out_in, ld_out_skid, ld_skid;
  logic [XLEN-1:0] d_imm, d_tgt;
  imm_type_t       d_type;
  logic            d_ill;

  otter_immed_decode #(.XLEN(XLEN)) u_decode (
    .ir_i      (IN_IR),
    .pc_i      (IN_PC),
    .imm_o     (d_imm),
    .type_o    (d_type),
    .target_o  (d_tgt),
    .illegal_o (d_ill)
  );

  assign dec = '{imm: d_imm, typ: d_type, tgt: d_tgt, ir: IN_IR, pc: IN_PC, ill: d_ill};

  // rdy_q is held low through reset; without a skid it only gates the combinational ready.
  assign IN_READY  = SKID ? rdy_q : (rdy_q & (~OUT_VALID | OUT_READY));
  assign OUT_VALID = (state_q != ST_EMPTY);
  assign in_fire   = IN_VALID & IN_READY;
  assign out_fire  = OUT_VALID & OUT_READY;

  always_comb begin
    state_d     = state_q;
    ld_out_in   = 1'b0;
    ld_out_skid = 1'b0;
    ld_skid     = 1'b0;
    if (FLUSH) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (in_fire) begin ld_out_in = 1'b1; state_d = ST_ONE; end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            ld_out_in = 1'b1;
          end else if (in_fire) begin
            if (SKID) begin ld_skid = 1'b1; state_d = ST_FULL; end
            else    ld_out_in = 1'b1;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: if (out_fire) begin ld_out_skid = 1'b1; state_d = ST_ONE; end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_EMPTY;
      rdy_q   <= 1'b0;
      out_q   <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= SKID ? (state_d != ST_FULL) : 1'b1;
      if (ld_out_in)        out_q <= dec;
      else if (ld_out_skid) out_q <= skid_q;
      if (ld_skid)          skid_q <= dec;
    end
  end

  assign OUT_IMM     = out_q.imm;
  assign OUT_TYPE    = out_q.typ;
  assign OUT_TARGET  = out_q.tgt;
  assign OUT_IR      = out_q.ir;
  assign OUT_PC      = out_q.pc;
  assign OUT_ILLEGAL = out_q.ill;

endmodule

// File: tb/tb_otter_immed_gen_pipe.sv
// Bench for otter_immed_gen_pipe: a 32-bit skid instance and a 64-bit no-skid
// instance checked against an arithmetic reference decoder and a FIFO scoreboard.
module tb_otter_immed_gen_pipe;

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  typ;
    logic [63:0] tgt;
    logic [31:0] ir;
    logic [63:0] pc;
    logic        ill;
  } exp_t;

  logic clk, rst_n, flush;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_illegal;
  logic [31:0] a_ir, a_pc, a_out_imm, a_out_target, a_out_ir, a_out_pc;
  logic [2:0]  a_out_type;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_illegal;
  logic [31:0] b_ir, b_out_ir;
  logic [63:0] b_pc, b_out_imm, b_out_target, b_out_pc;
  logic [2:0]  b_out_type;

  int checks = 0;
  int errors = 0;

  otter_immed_gen_pipe #(.XLEN(32), .SKID(1'b1)) dut32 (
    .CLK(clk), .RST_N(rst_n), .FLUSH(flush),
    .IN_VALID(a_in_valid), .IN_READY(a_in_ready), .IN_IR(a_ir), .IN_PC(a_pc),
    .OUT_VALID(a_out_valid), .OUT_READY(a_out_ready), .OUT_IMM(a_out_imm),
    .OUT_TYPE(a_out_type), .OUT_TARGET(a_out_target), .OUT_IR(a_out_ir),
    .OUT_PC(a_out_pc), .OUT_ILLEGAL(a_out_illegal)
  );

  otter_immed_gen_pipe #(.XLEN(64), .SKID(1'b0)) dut64 (
    .CLK(clk), .RST_N(rst_n), .FLUSH(flush),
    .IN_VALID(b_in_valid), .IN_READY(b_in_ready), .IN_IR(b_ir), .IN_PC(b_pc),
    .OUT_VALID(b_out_valid), .OUT_READY(b_out_ready), .OUT_IMM(b_out_imm),
    .OUT_TYPE(b_out_type), .OUT_TARGET(b_out_target), .OUT_IR(b_out_ir),
    .OUT_PC(b_out_pc), .OUT_ILLEGAL(b_out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] sext(input logic [63:0] v, input int bits);
    logic [63:0] s;
    s = 64'd1 << bits - 1;
    return (v ^ s) - s;
  endfunction

  // Field arithmetic straight from the instruction-format tables.
  function automatic exp_t ref_model(input logic [31:0] ir, input logic [63:0] pc, input bit x64);
    exp_t        e;
    logic [63:0] mask;
    bit          rel, sh;
    mask  = x64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    sh    = (ir[14:12] == 3'd1) || (ir[14:12] == 3'd5);
    e.imm = 64'd0; e.typ = 3'd0; e.ill = 1'b0; rel = 1'b0;
    e.ir  = ir; e.pc = pc & mask;
    if (ir[1:0] != 2'b11) e.ill = 1'b1;
    else case (ir[6:0])
      7'h37: begin e.typ = 3'd4; e.imm = sext(64'(ir[31:12]) * 64'd4096, 32); end
      7'h17: begin e.typ = 3'd4; e.imm = sext(64'(ir[31:12]) * 64'd4096, 32); rel = 1'b1; end
      7'h6F: begin
        e.typ = 3'd5; rel = 1'b1;
        e.imm = sext(64'(ir[31]) * 64'd1048576 + 64'(ir[19:12]) * 64'd4096
                   + 64'(ir[20]) * 64'd2048 + 64'(ir[30:21]) * 64'd2, 21);
      end
      7'h67, 7'h03, 7'h73: begin e.typ = 3'd1; e.imm = sext(64'(ir[31:20]), 12); end
      7'h13: begin
        if (sh) begin e.typ = 3'd6; e.imm = x64 ? 64'(ir[25:20]) : 64'(ir[24:20]); end
        else    begin e.typ = 3'd1; e.imm = sext(64'(ir[31:20]), 12); end
      end
      7'h1B: begin
        if (!x64)    e.ill = 1'b1;
        else if (sh) begin e.typ = 3'd6; e.imm = 64'(ir[24:20]); end
        else         begin e.typ = 3'd1; e.imm = sext(64'(ir[31:20]), 12); end
      end
      7'h23: begin e.typ = 3'd2; e.imm = sext(64'(ir[31:25]) * 64'd32 + 64'(ir[11:7]), 12); end
      7'h63: begin
        e.typ = 3'd3; rel = 1'b1;
        e.imm = sext(64'(ir[31]) * 64'd4096 + 64'(ir[7]) * 64'd2048
                   + 64'(ir[30:25]) * 64'd32 + 64'(ir[11:8]) * 64'd2, 13);
      end
      7'h33: e.typ = 3'd0;
      7'h3B: e.ill = !x64;
      default: e.ill = 1'b1;
    endcase
    e.imm = e.imm & mask;
    e.tgt = rel ? ((e.pc + e.imm) & mask) : 64'd0;
    return e;
  endfunction

  function automatic logic [31:0] rand_ir();
    logic [6:0]  ops [12];
    logic [31:0] r;
    int unsigned sel;
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h1B, 7'h33, 7'h3B, 7'h73};
    r   = $urandom();
    sel = $urandom_range(0, 13);
    if (sel < 12)       return {r[31:7], ops[sel]};
    else if (sel == 12) return r;
    else                return {r[31:2], 2'b01};
  endfunction

  // Single transfer on the 32-bit instance with the consumer always ready.
  task automatic xfer32(input logic [31:0] ir, input logic [31:0] pc, output exp_t got, output bit ok);
    int n;
    a_ir = ir; a_pc = pc; a_in_valid = 1'b1; a_out_ready = 1'b1;
    #1;
    n = 0;
    while (!a_in_ready && n < 20) begin @(negedge clk); #1; n++; end
    ok = a_in_ready;
    @(posedge clk); #1; a_in_valid = 1'b0;
    @(negedge clk);
    got.imm = {32'd0, a_out_imm}; got.typ = a_out_type; got.tgt = {32'd0, a_out_target};
    got.ir = a_out_ir; got.pc = {32'd0, a_out_pc}; got.ill = a_out_illegal;
    ok = ok && a_out_valid;
    @(negedge clk);
  endtask

  task automatic xfer64(input logic [31:0] ir, input logic [63:0] pc, output exp_t got, output bit ok);
    int n;
    b_ir = ir; b_pc = pc; b_in_valid = 1'b1; b_out_ready = 1'b1;
    #1;
    n = 0;
    while (!b_in_ready && n < 20) begin @(negedge clk); #1; n++; end
    ok = b_in_ready;
    @(posedge clk); #1; b_in_valid = 1'b0;
    @(negedge clk);
    got.imm = b_out_imm; got.typ = b_out_type; got.tgt = b_out_target;
    got.ir = b_out_ir; got.pc = b_out_pc; got.ill = b_out_illegal;
    ok = ok && b_out_valid;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0;
    a_in_valid = 1'b0; a_out_ready = 1'b0; a_ir = '0; a_pc = '0;
    b_in_valid = 1'b0; b_out_ready = 1'b0; b_ir = '0; b_pc = '0;
    repeat (2) @(negedge clk);
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_a_out_valid: got %b expected 0", a_out_valid); end
    checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL reset_a_in_ready: got %b expected 0", a_in_ready); end
    checks++; if ({a_out_imm, a_out_target, a_out_ir, a_out_pc} !== 128'd0) begin errors++; $display("FAIL reset_a_data: got imm=%h tgt=%h expected 0", a_out_imm, a_out_target); end
    checks++; if (b_out_valid !== 1'b0 || b_in_ready !== 1'b0) begin errors++; $display("FAIL reset_b_handshake: got valid=%b ready=%b expected 0 0", b_out_valid, b_in_ready); end
    checks++; if (b_out_imm !== 64'd0) begin errors++; $display("FAIL reset_b_imm: got %h expected 0", b_out_imm); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got a=%b b=%b expected 1 1", a_in_ready, b_in_ready); end
  endtask

  task automatic test_decode32();
    logic [31:0] irs [7];
    logic [63:0] imms [7], tgts [7];
    logic [2:0]  typs [7];
    logic        ills [7];
    exp_t got; bit ok;
    irs  = '{32'h0040006F, 32'hFE000CE3, 32'h4030D093, 32'h00000000, 32'h0000007F, 32'h03F09093, 32'h0000003B};
    imms = '{64'h4, 64'hFFFF_FFF8, 64'h3, 64'h0, 64'h0, 64'h1F, 64'h0};
    typs = '{3'd5, 3'd3, 3'd6, 3'd0, 3'd0, 3'd6, 3'd0};
    tgts = '{64'h104, 64'h1F8, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0};
    ills = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 7; i++) begin
      xfer32(irs[i], 32'h100 * (i + 1), got, ok);
      checks++; if (!ok) begin errors++; $display("FAIL dec32_handshake[%0d]: got no output expected one", i); end
      checks++; if (got.imm !== imms[i]) begin errors++; $display("FAIL dec32_imm[%0d]: got %h expected %h", i, got.imm, imms[i]); end
      checks++; if (got.typ !== typs[i]) begin errors++; $display("FAIL dec32_type[%0d]: got %0d expected %0d", i, got.typ, typs[i]); end
      checks++; if (got.tgt !== tgts[i]) begin errors++; $display("FAIL dec32_target[%0d]: got %h expected %h", i, got.tgt, tgts[i]); end
      checks++; if (got.ill !== ills[i] || got.ir !== irs[i]) begin errors++; $display("FAIL dec32_ill_ir[%0d]: got %b/%h expected %b/%h", i, got.ill, got.ir, ills[i], irs[i]); end
    end
  endtask

  task automatic test_decode64();
    logic [31:0] irs [6];
    logic [63:0] pcs [6], imms [6], tgts [6];
    logic [2:0]  typs [6];
    exp_t got; bit ok;
    irs  = '{32'h800000B7, 32'hFFFFF017, 32'h03F0909B, 32'h03F09093, 32'h0000003B, 32'hFFDFF06F};
    pcs  = '{64'h1000, 64'h12345, 64'h0, 64'h0, 64'h0, 64'h2};
    imms = '{64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_FFFF_F000, 64'h1F, 64'h3F, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC};
    typs = '{3'd4, 3'd4, 3'd6, 3'd6, 3'd0, 3'd5};
    tgts = '{64'h0, 64'h11345, 64'h0, 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFE};
    for (int i = 0; i < 6; i++) begin
      xfer64(irs[i], pcs[i], got, ok);
      checks++; if (!ok) begin errors++; $display("FAIL dec64_handshake[%0d]: got no output expected one", i); end
      checks++; if (got.imm !== imms[i]) begin errors++; $display("FAIL dec64_imm[%0d]: got %h expected %h", i, got.imm, imms[i]); end
      checks++; if (got.typ !== typs[i] || got.ill !== 1'b0) begin errors++; $display("FAIL dec64_type[%0d]: got %0d/%b expected %0d/0", i, got.typ, got.ill, typs[i]); end
      checks++; if (got.tgt !== tgts[i] || got.pc !== pcs[i]) begin errors++; $display("FAIL dec64_target[%0d]: got %h expected %h", i, got.tgt, tgts[i]); end
    end
  endtask

  task automatic test_random64();
    exp_t got, e; bit ok;
    logic [31:0] ir; logic [63:0] pc;
    for (int i = 0; i < 40; i++) begin
      ir = rand_ir(); pc = {32'($urandom()), 32'($urandom())};
      e = ref_model(ir, pc, 1'b1);
      xfer64(ir, pc, got, ok);
      checks++;
      if (!ok || got !== e) begin
        errors++;
        $display("FAIL rand64[%0d]: ir=%h got imm=%h typ=%0d tgt=%h ill=%b expected imm=%h typ=%0d tgt=%h ill=%b",
                 i, ir, got.imm, got.typ, got.tgt, got.ill, e.imm, e.typ, e.tgt, e.ill);
      end
    end
  endtask

  // Random traffic and back-pressure on the skid instance against a FIFO scoreboard.
  task automatic test_random_stream();
    exp_t q[$]; exp_t e, snap;
    bit pend, stall, in_f, out_f, drain;
    pend = 1'b0; stall = 1'b0;
    for (int cyc = 0; cyc < 430; cyc++) begin
      drain = (cyc >= 400);
      if (stall) begin
        checks++;
        if ({32'd0, a_out_imm} !== snap.imm || a_out_type !== snap.typ || {32'd0, a_out_target} !== snap.tgt
            || a_out_ir !== snap.ir || {32'd0, a_out_pc} !== snap.pc || a_out_illegal !== snap.ill) begin
          errors++; $display("FAIL stream_hold[%0d]: got ir=%h expected ir=%h held", cyc, a_out_ir, snap.ir);
        end
      end
      checks++; if (a_out_valid !== (q.size() != 0)) begin errors++; $display("FAIL stream_valid[%0d]: got %b expected %b", cyc, a_out_valid, q.size() != 0); end
      checks++; if (a_in_ready !== (q.size() < 2)) begin errors++; $display("FAIL stream_ready[%0d]: got %b expected %b", cyc, a_in_ready, q.size() < 2); end
      if (drain) a_in_valid = 1'b0;
      else if (!pend) begin
        a_in_valid = ($urandom_range(0, 3) != 0);
        a_ir = rand_ir(); a_pc = $urandom();
      end
      a_out_ready = drain || ($urandom_range(0, 2) != 0);
      #1;
      in_f = a_in_valid && a_in_ready; out_f = a_out_valid && a_out_ready;
      if (out_f) begin
        checks++;
        if (q.size() == 0) begin errors++; $display("FAIL stream_order[%0d]: got ir=%h expected no output", cyc, a_out_ir); end
        else begin
          e = q.pop_front();
          if ({32'd0, a_out_imm} !== e.imm || a_out_type !== e.typ || {32'd0, a_out_target} !== e.tgt
              || a_out_ir !== e.ir || {32'd0, a_out_pc} !== e.pc || a_out_illegal !== e.ill) begin
            errors++;
            $display("FAIL stream_data[%0d]: got ir=%h imm=%h typ=%0d tgt=%h ill=%b expected ir=%h imm=%h typ=%0d tgt=%h ill=%b",
                     cyc, a_out_ir, a_out_imm, a_out_type, a_out_target, a_out_illegal, e.ir, e.imm, e.typ, e.tgt, e.ill);
          end
        end
      end
      if (in_f) q.push_back(ref_model(a_ir, {32'd0, a_pc}, 1'b0));
      pend  = a_in_valid && !in_f;
      stall = a_out_valid && !a_out_ready;
      snap.imm = {32'd0, a_out_imm}; snap.typ = a_out_type; snap.tgt = {32'd0, a_out_target};
      snap.ir = a_out_ir; snap.pc = {32'd0, a_out_pc}; snap.ill = a_out_illegal;
      @(negedge clk);
    end
    checks++; if (q.size() != 0 || a_out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain: got %0d pending valid=%b expected 0 0", q.size(), a_out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [3];
    logic [31:0] got [$];
    int idx, first, last;
    bit in_f, out_f;
    vals = '{32'h00100093, 32'h00200113, 32'h00300193};
    idx = 0; first = -1; last = -1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      a_in_valid = (idx < 3);
      if (idx < 3) a_ir = vals[idx];
      a_pc = 32'h40; a_out_ready = (cyc >= 4);
      #1;
      if (cyc == 3) begin
        checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_ready: got %b expected 0", a_in_ready); end
        checks++; if (a_out_valid !== 1'b1 || a_out_ir !== vals[0]) begin errors++; $display("FAIL b2b_stall_head: got %b/%h expected 1/%h", a_out_valid, a_out_ir, vals[0]); end
      end
      in_f = a_in_valid && a_in_ready; out_f = a_out_valid && a_out_ready;
      if (out_f) begin got.push_back(a_out_ir); if (first < 0) first = cyc; last = cyc; end
      if (in_f) idx++;
      @(negedge clk);
    end
    a_in_valid = 1'b0;
    checks++; if (got.size() != 3) begin errors++; $display("FAIL b2b_count: got %0d expected 3", got.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= got.size()) begin errors++; $display("FAIL b2b_order[%0d]: got nothing expected %h", i, vals[i]); end
      else if (got[i] !== vals[i]) begin errors++; $display("FAIL b2b_order[%0d]: got %h expected %h", i, got[i], vals[i]); end
    end
    checks++; if (first != 4 || last != 6) begin errors++; $display("FAIL b2b_timing: got cycles %0d..%0d expected 4..6", first, last); end
  endtask

  task automatic test_skid0_replace();
    b_out_ready = 1'b0; b_in_valid = 1'b1; b_ir = 32'h00500513; b_pc = 64'h80;
    @(posedge clk); @(negedge clk);
    b_ir = 32'h00600593;
    #1;
    checks++; if (b_in_ready !== 1'b0 || b_out_ir !== 32'h00500513) begin errors++; $display("FAIL skid0_stall: got ready=%b ir=%h expected 0/00500513", b_in_ready, b_out_ir); end
    @(negedge clk);
    b_out_ready = 1'b1;
    #1;
    checks++; if (b_in_ready !== 1'b1) begin errors++; $display("FAIL skid0_ready_passthru: got %b expected 1", b_in_ready); end
    @(posedge clk); #1; b_in_valid = 1'b0;
    @(negedge clk);
    checks++; if (b_out_valid !== 1'b1 || b_out_ir !== 32'h00600593) begin errors++; $display("FAIL skid0_replace: got %b/%h expected 1/00600593", b_out_valid, b_out_ir); end
    @(negedge clk);
    checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL skid0_drain: got %b expected 0", b_out_valid); end
  endtask

  task automatic test_flush();
    bit seen;
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_ir = 32'h00100093; a_pc = 32'h10;
    @(posedge clk); @(negedge clk);
    a_ir = 32'h00200113;
    @(posedge clk); @(negedge clk);
    checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL flush_pre_full: got ready=%b expected 0", a_in_ready); end
    a_ir = 32'h00A00293; flush = 1'b1;
    @(posedge clk); @(negedge clk);
    flush = 1'b0; a_in_valid = 1'b0;
    checks++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin errors++; $display("FAIL flush_state: got valid=%b ready=%b expected 0 1", a_out_valid, a_in_ready); end
    a_out_ready = 1'b1; seen = 1'b0;
    repeat (4) begin @(negedge clk); if (a_out_valid !== 1'b0) seen = 1'b1; end
    checks++; if (seen) begin errors++; $display("FAIL flush_discard: got an output expected none"); end
  endtask

  task automatic test_async_reset();
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_ir = 32'h00700393; a_pc = 32'h20;
    @(posedge clk); @(negedge clk);
    a_in_valid = 1'b0;
    checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL areset_pre_stall: got %b expected 1", a_out_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b0) begin errors++; $display("FAIL areset_immediate: got valid=%b ready=%b expected 0 0", a_out_valid, a_in_ready); end
    checks++; if (a_out_imm !== 32'd0 || a_out_ir !== 32'd0) begin errors++; $display("FAIL areset_data: got imm=%h ir=%h expected 0 0", a_out_imm, a_out_ir); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL areset_release: got %b expected 1", a_in_ready); end
  endtask

  initial begin
    test_reset();
    test_decode32();
    test_decode64();
    test_random64();
    test_random_stream();
    test_back_to_back();
    test_skid0_replace();
    test_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no completion expected finish");
    $fatal(1);
  end

endmodule

// File: doc/otter_immed_gen_pipe.md
Name: otter_immed_gen_pipe

Overview:
Parametrised, pipelined successor to the OTTER combinational immediate generator. It accepts one instruction and its PC per valid/ready handshake and decodes the opcode to select the immediate format. It emits one sign-extended XLEN immediate, its format tag, and the PC-relative target. It sits between fetch and decode with a registered output and an optional skid buffer, so the decode stage sees a timing-clean, stall-tolerant interface.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64.
SKID, 1, 1 = two-entry buffer with registered IN_READY; 0 = single output register with combinational IN_READY.

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  reset, asynchronous, active-low
FLUSH  in  1  synchronous pipeline flush
IN_VALID  in  1  input instruction valid
IN_READY  out  1  block can accept input
IN_IR  in  32  instruction word
IN_PC  in  XLEN  instruction address
OUT_VALID  out  1  output valid
OUT_READY  in  1  consumer accepts output
OUT_IMM  out  XLEN  selected, extended immediate
OUT_TYPE  out  3  imm_type_t format tag
OUT_TARGET  out  XLEN  PC+imm for B/J/AUIPC, else 0
OUT_IR  out  32  instruction passed through
OUT_PC  out  XLEN  PC passed through
OUT_ILLEGAL  out  1  unsupported opcode or IR[1:0] != 2'b11

Behaviour:
- Reset (RST_N low, async): OUT_VALID=0, IN_READY=0, all data outputs 0, buffer state EMPTY. IN_READY=1 from the first edge after release.
- Format decode (IR[6:0]):
  - U: 0110111, 0010111. imm = IR[31:12]<<12, sign-extended from bit 31 to XLEN.
  - J: 1101111. imm = {IR[31],IR[19:12],IR[20],IR[30:21],0}.
  - I: 1100111, 0000011, 1110011, plus 0010011 when funct3 is not 001/101. imm = IR[31:20] sign-extended.
  - SH: 0010011 with funct3 001/101. imm = zero-extended shamt; IR[24:20] when XLEN=32, IR[25:20] when XLEN=64.
  - XLEN=64 only: 0011011 decodes as I, or SH with shamt IR[24:20].
  - S: 0100011. imm = {IR[31:25],IR[11:7]} sign-extended.
  - B: 1100011. imm = {IR[31],IR[7],IR[30:25],IR[11:8],0} sign-extended.
  - R: 0110011 (and 0111011 when XLEN=64). imm = 0.
  - Anything else, or IR[1:0] != 11: OUT_ILLEGAL=1, OUT_TYPE=R, imm=0, target=0. The entry still flows through the pipe.
- Target: B, J, AUIPC give OUT_TARGET = PC+imm modulo 2^XLEN; overflow wraps silently. JALR and all other formats give 0.
- Latency: an accepted input appears on the outputs at the next rising edge. Outputs are fully registered; no input-to-output combinational path.
- Transfer rules: input transfer when IN_VALID&IN_READY; output transfer when OUT_VALID&OUT_READY. Outputs hold stable while OUT_VALID&!OUT_READY.
- SKID=1 state machine (IN_READY = state!=FULL):
  - EMPTY --in--> ONE.
  - ONE: in&!out -> FULL (new entry goes to skid register); in&out -> ONE; out only -> EMPTY.
  - FULL: out -> ONE (skid moves to output register); no input is accepted in FULL.
- SKID=0: IN_READY = !OUT_VALID | OUT_READY. Simultaneous in/out replaces the output register.
- Order is strictly FIFO; no drop or duplication except on FLUSH.
- FLUSH: at the next edge all entries are cleared, state=EMPTY, OUT_VALID=0. Any input offered that cycle is discarded, even if IN_READY=1. FLUSH dominates simultaneous in/out.
- Data registers update only on load, never on hold, so the verifier can check hold stability.

Decomposition:
- Package otter_immed_pkg holds:
  - opcode localparams (OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_IMM32, OP_REG, OP_REG32, OP_SYSTEM);
  - typedef enum logic[2:0] imm_type_t {IMM_R=0, IMM_I=1, IMM_S=2, IMM_B=3, IMM_U=4, IMM_J=5, IMM_SH=6}.
- Sub-module otter_immed_decode #(XLEN): purely combinational IR,PC -> imm, type, target, illegal. It is instantiated once, before the pipeline registers.
- The top level contains only the handshake/skid state machine and the registers.

Test Plan:
1. XLEN=32, IR=0x0040006F (JAL +4), PC=0x100 -> one cycle later OUT_IMM=0x4, TYPE=J, TARGET=0x104, ILLEGAL=0.
2. IR=0xFE000CE3 (BEQ -8), PC=0x200 -> OUT_IMM=0xFFFFFFF8, TYPE=B, TARGET=0x1F8. Also IR=0x4030D093 (SRAI 3) -> OUT_IMM=0x3, TYPE=SH.
3. XLEN=64, IR=0x800000B7 (LUI) -> OUT_IMM=0xFFFFFFFF80000000, TYPE=U, TARGET=0.
4. SKID=1, OUT_READY=0, three back-to-back inputs A,B,C -> A,B accepted, IN_READY=0 while FULL, C held by source. Raise OUT_READY -> A,B,C delivered in order, one per cycle, none lost or duplicated.
5. FULL state, FLUSH=1 with IN_VALID=1 -> next cycle OUT_VALID=0, IN_READY=1, flushed input never appears.
6. IR=0x00000000 and IR=0x0000007F -> OUT_ILLEGAL=1, OUT_IMM=0. RST_N driven low mid-stall -> OUT_VALID=0 immediately, without waiting for a clock edge.
